// File: rtl/mux_select_scanner.sv
// ---------------------------------------------------------------------------
// mux_select_scanner
//
// Generates the 2-bit select pair for the 4-to-1 switch multiplexer.
// sel[1] drives the second-level mux. sel[0] drives both first-level muxes.
//
// The select source depends on the registered mode (state):
//   MANUAL    : sel follows manual_sel on every clock edge.
//   SCAN_UP   : sel increments (mod 4) once every DIV_MAX+1 clocks.
//   SCAN_DOWN : sel decrements (mod 4) once every DIV_MAX+1 clocks.
//   STEP      : sel increments (mod 4) once per press of step_n.
//
// tick pulses for one cycle in the cycle after sel changes value.
// A downstream display uses it to refresh.
//
// Ports
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   mode        in   [1:0] 00 MANUAL, 01 SCAN_UP, 10 SCAN_DOWN, 11 STEP
//   manual_sel  in   [1:0] select value used in MANUAL
//   step_n      in   active-low push button, asynchronous to clock
//   sel         out  [1:0] registered mux select
//   tick        out  registered one-cycle change pulse
//   state_dbg   out  [1:0] current FSM state, for observation only
//
// Every output is driven directly by a flop, so no input reaches sel or tick
// through combinational logic.
// ---------------------------------------------------------------------------
module mux_select_scanner #(
   parameter int          DIV_WIDTH = 26,
   parameter int unsigned DIV_MAX   = 49_999_999
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [1:0] mode,
   input  logic [1:0] manual_sel,
   input  logic       step_n,
   output logic [1:0] sel,
   output logic       tick,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_MANUAL    = 2'b00,
      ST_SCAN_UP   = 2'b01,
      ST_SCAN_DOWN = 2'b10,
      ST_STEP      = 2'b11
   } state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_TC = DIV_WIDTH'(DIV_MAX);

   state_t               state;
   state_t               mode_state;
   logic [DIV_WIDTH-1:0] div_count;
   logic                 step_sync1;
   logic                 step_sync2;
   logic                 step_hist;

   logic                 mode_change;
   logic                 scanning;
   logic                 advance;
   logic                 step_pulse;
   logic [1:0]           next_sel;

   assign mode_state  = state_t'(mode);
   assign mode_change = (mode_state != state);
   assign scanning    = (state == ST_SCAN_UP) || (state == ST_SCAN_DOWN);

   // A mode change overrides the divider terminal count. The advance is
   // dropped and the count restarts, so the new scan always waits a full
   // period.
   assign advance = scanning && !mode_change && (div_count == DIV_TC);

   // The history flop holds the previous synchronized level. A 1 -> 0 step
   // gives exactly one pulse per press, however long the button is held.
   assign step_pulse = !step_sync2 && step_hist;

   // Next select value.
   // The behaviour is chosen by the registered state, not by the raw mode.
   // On the edge where mode changes, the old state's rule still applies.
   always_comb begin
      next_sel = sel;
      case (state)
         ST_MANUAL:    next_sel = manual_sel;
         ST_SCAN_UP:   if (advance) next_sel = sel + 2'd1;
         ST_SCAN_DOWN: if (advance) next_sel = sel - 2'd1;
         ST_STEP:      if (step_pulse) next_sel = sel + 2'd1;
         default:      next_sel = sel;
      endcase
   end

   // State register, rate divider, step synchronizer and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_MANUAL;
         div_count  <= '0;
         step_sync1 <= 1'b1;
         step_sync2 <= 1'b1;
         step_hist  <= 1'b1;
         sel        <= 2'b00;
         tick       <= 1'b0;
      end else begin
         state <= mode_state;

         // The divider runs only while scanning with a stable mode.
         if (!scanning || mode_change || advance) begin
            div_count <= '0;
         end else begin
            div_count <= div_count + 1'b1;
         end

         step_sync1 <= step_n;
         step_sync2 <= step_sync1;
         step_hist  <= step_sync2;

         sel  <= next_sel;
         // Compare against the next value rather than the load source.
         // Reloading an unchanged value then produces no tick.
         tick <= (next_sel != sel);
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_mux_select_scanner.sv
// ---------------------------------------------------------------------------
// tb_mux_select_scanner
//
// Bench for mux_select_scanner with a short scan period (DIV_MAX=3).
//
// The reference model advances once per clock edge. It derives sel from
// three quantities:
//   - the number of edges spent in the current scan state,
//   - a short history of sampled step_n levels,
//   - the previously applied mode.
// The directed sections pin the model with hand-computed literals. A random
// section then exercises mode, manual_sel and step_n together.
// ---------------------------------------------------------------------------
module tb_mux_select_scanner;

   localparam int DW   = 4;
   localparam int DMAX = 3;

   logic       clock;
   logic       resetn;
   logic [1:0] mode;
   logic [1:0] manual_sel;
   logic       step_n;
   logic [1:0] sel;
   logic       tick;
   logic [1:0] state_dbg;

   int vectors;
   int miscompares;
   bit run_checks;

   mux_select_scanner #(.DIV_WIDTH(DW), .DIV_MAX(DMAX)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .mode       (mode),
      .manual_sel (manual_sel),
      .step_n     (step_n),
      .sel        (sel),
      .tick       (tick),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   logic [1:0]  m_state;
   logic [1:0]  m_sel;
   logic        m_tick;
   int unsigned m_run;          // edges spent in the current scan state
   logic        smp [1:3];      // smp[k] = step_n sampled k edges ago

   always @(posedge clock or negedge resetn) begin
      logic [1:0] nsel;
      logic       press;
      if (!resetn) begin
         m_state = 2'b00;
         m_sel   = 2'b00;
         m_tick  = 1'b0;
         m_run   = 0;
         for (int k = 1; k <= 3; k++) smp[k] = 1'b1;
      end else begin
         // A press is a 1 -> 0 step, seen after the two-flop sync delay.
         press = (smp[2] == 1'b0) && (smp[3] == 1'b1);
         nsel  = m_sel;
         case (m_state)
            2'b00: nsel = manual_sel;
            2'b01, 2'b10: begin
               if (mode == m_state) begin
                  m_run = m_run + 1;
                  if (m_run % (DMAX + 1) == 0)
                     nsel = (m_state == 2'b01) ? m_sel + 2'd1 : m_sel - 2'd1;
               end
            end
            default: if (press) nsel = m_sel + 2'd1;
         endcase
         if (mode != m_state) m_run = 0;
         m_tick  = (nsel != m_sel);
         m_sel   = nsel;
         m_state = mode;
         smp[3]  = smp[2];
         smp[2]  = smp[1];
         smp[1]  = step_n;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Compare the DUT outputs against the model on every falling edge.
   always @(negedge clock) begin
      if (resetn && run_checks) begin
         check("sel",   {6'd0, sel},       {6'd0, m_sel});
         check("tick",  {7'd0, tick},      {7'd0, m_tick});
         check("state", {6'd0, state_dbg}, {6'd0, m_state});
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      run_checks  = 1'b0;
      resetn      = 1'b0;
      mode        = 2'b00;
      manual_sel  = 2'b00;
      step_n      = 1'b1;

      // Reset state.
      wait_n(2);
      check("rst_sel",   {6'd0, sel},       8'h00);
      check("rst_tick",  {7'd0, tick},      8'h00);
      check("rst_state", {6'd0, state_dbg}, 8'h00);
      #2 resetn = 1'b1;
      run_checks = 1'b1;

      // Scan up from reset: 00,01,10,11,00, with one change every 4 edges.
      wait_n(1);
      mode = 2'b01;
      wait_n(1);                     // state update edge E
      for (int k = 1; k <= 4; k++) begin
         wait_n(3);
         check("up_hold", {6'd0, sel}, 8'((k - 1) % 4));
         wait_n(1);
         check("up_adv",  {6'd0, sel}, 8'(k % 4));
         check("up_tick", {7'd0, tick}, 8'h01);
      end

      // Reset mid-scan with sel=10. The outputs clear before any clock edge.
      wait_n(8);
      check("pre_rst_sel", {6'd0, sel}, 8'h02);
      @(posedge clock);
      #3 resetn = 1'b0;
      #1;
      check("async_sel",   {6'd0, sel},       8'h00);
      check("async_tick",  {7'd0, tick},      8'h00);
      check("async_state", {6'd0, state_dbg}, 8'h00);
      @(negedge clock);
      #2 resetn = 1'b1;
      #1 check("post_rst_state", {6'd0, state_dbg}, 8'h00);
      mode       = 2'b00;
      manual_sel = 2'b01;
      wait_n(1);
      check("man_load", {6'd0, sel}, 8'h01);

      // Scan down from 01: 00, then 11, then 10 (wraps 00 -> 11).
      wait_n(1);
      mode = 2'b10;
      wait_n(1);
      wait_n(4);
      check("dn_1", {6'd0, sel}, 8'h00);
      wait_n(4);
      check("dn_wrap", {6'd0, sel}, 8'h03);
      wait_n(4);
      check("dn_3", {6'd0, sel}, 8'h02);

      // Manual: load 10 with one tick, then no further tick while it is held.
      mode       = 2'b00;
      manual_sel = 2'b00;
      wait_n(3);
      manual_sel = 2'b10;
      wait_n(1);
      check("man_sel",  {6'd0, sel},  8'h02);
      check("man_tick", {7'd0, tick}, 8'h01);
      for (int k = 0; k < 10; k++) begin
         wait_n(1);
         check("man_quiet", {7'd0, tick}, 8'h00);
      end

      // Step: a held button gives one advance, two edges after the first sample.
      mode = 2'b11;
      wait_n(2);
      step_n = 1'b0;
      wait_n(2);
      check("step_wait", {6'd0, sel}, 8'h02);
      wait_n(1);
      check("step_adv",  {6'd0, sel},  8'h03);
      check("step_tick", {7'd0, tick}, 8'h01);
      wait_n(17);
      step_n = 1'b1;
      wait_n(5);
      check("step_once", {6'd0, sel}, 8'h03);

      // A step press in scan is discarded. The 01 -> 10 switch at count=2
      // clears the count, so the next move is a decrement 4 edges later.
      mode = 2'b01;
      wait_n(1);
      step_n = 1'b0;
      wait_n(2);
      mode   = 2'b10;
      step_n = 1'b1;
      wait_n(1);
      check("sw_no_adv", {6'd0, sel}, 8'h03);
      wait_n(3);
      check("sw_hold", {6'd0, sel}, 8'h03);
      wait_n(1);
      check("sw_dec",  {6'd0, sel},  8'h02);
      check("sw_tick", {7'd0, tick}, 8'h01);

      // Randomized mix; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
         if ($urandom_range(7, 0) == 0)  manual_sel = 2'($urandom_range(3, 0));
         if ($urandom_range(5, 0) == 0)  step_n = ~step_n;
         wait_n(1);
      end

      run_checks = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
